// File: rtl/alu_mul_seq.sv
// 8x8 unsigned shift-and-add multiplier that borrows the shared 8-bit ALU.
// Owns the ALU only in ADD/SHIFT; the core muxes alu_op/alu_r/alu_dr/alu_c in.
module alu_mul_seq #(
  parameter bit         SKIP_ZERO = 1'b0,
  parameter logic [8:0] IDLE_OP   = 9'h000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product,
  output logic        o_alu_own,
  output logic [8:0]  o_alu_op,
  output logic [7:0]  o_alu_r,
  output logic [7:0]  o_alu_dr,
  output logic        o_alu_c,
  input  logic [7:0]  i_alu_out,
  input  logic        i_alu_co
);

  // state | meaning
  // IDLE  | waiting for start, ALU released
  // ADD   | hi += m when lo[0] is set, carry captured into c
  // SHIFT | rotate {c,hi,lo} right by one through the ALU
  // DONE  | one-cycle done pulse, product valid
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0] OP_ADD  = 9'h004;
  localparam logic [8:0] OP_PASS = 9'h000;
  localparam logic [8:0] OP_ROR  = 9'h183;

  logic [1:0] r_state;
  logic [7:0] r_m;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic       r_c;
  logic [2:0] r_iter;

  always_comb begin
    o_alu_op = IDLE_OP;
    o_alu_r  = 8'h00;
    o_alu_dr = 8'h00;
    o_alu_c  = 1'b0;
    case (r_state)
      S_ADD: begin
        o_alu_op = r_lo[0] ? OP_ADD : OP_PASS;
        o_alu_r  = r_hi;
        o_alu_dr = r_m;
      end
      S_SHIFT: begin
        o_alu_op = OP_ROR;
        o_alu_r  = r_hi;
        o_alu_c  = r_c;
      end
      default: ;
    endcase
  end

  assign o_busy    = (r_state == S_ADD) || (r_state == S_SHIFT);
  assign o_alu_own = o_busy;
  assign o_done    = (r_state == S_DONE);
  // hi/lo are untouched after the last shift, so the product holds until the next start reloads them
  assign o_product = {r_hi, r_lo};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_m     <= 8'h00;
      r_hi    <= 8'h00;
      r_lo    <= 8'h00;
      r_c     <= 1'b0;
      r_iter  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m     <= i_a;
            r_hi    <= 8'h00;
            r_lo    <= i_b;
            r_iter  <= 3'd0;
            r_c     <= 1'b0;
            r_state <= (SKIP_ZERO && !i_b[0]) ? S_SHIFT : S_ADD;
          end
        end
        S_ADD: begin
          if (r_lo[0]) begin
            r_hi <= i_alu_out;
            r_c  <= i_alu_co;
          end else begin
            r_c  <= 1'b0;
          end
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_hi   <= i_alu_out;
          r_lo   <= {i_alu_co, r_lo[7:1]};
          r_c    <= 1'b0;
          r_iter <= r_iter + 3'd1;
          // lo[1] is the multiplier bit that lands in lo[0] after this shift
          if (r_iter == 3'd7)
            r_state <= S_DONE;
          else if (SKIP_ZERO && !r_lo[1])
            r_state <= S_SHIFT;
          else
            r_state <= S_ADD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: fixed-latency (index 0) and skip-zero (index 1) instances,
// each wired to a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n;
  logic [1:0] start;
  logic [7:0] a [2];
  logic [7:0] b [2];
  logic [1:0] busy, done, own, alu_c, alu_co;
  logic [15:0] prod [2];
  logic [8:0]  op [2];
  logic [7:0]  r [2];
  logic [7:0]  dr [2];
  logic [7:0]  alu_out [2];

  logic [15:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [8:0] alu_f(input logic [8:0] f_op, input logic [7:0] f_r,
                                       input logic [7:0] f_dr, input logic f_c);
    logic       ci;
    logic [7:0] bb;
    case (f_op[1:0])
      2'd3:    ci = f_c;
      2'd1:    ci = 1'b1;
      default: ci = 1'b0;
    endcase
    if (f_op[8]) begin
      if (f_op[7]) return {f_r[0], ci, f_r[7:1]};
      else         return {f_r[7], f_r[6:0], ci};
    end
    bb = (f_op[3:2] == 2'd1) ? f_dr : 8'h00;
    return {1'b0, f_r} + {1'b0, bb} + {8'h00, ci};
  endfunction

  assign {alu_co[0], alu_out[0]} = alu_f(op[0], r[0], dr[0], alu_c[0]);
  assign {alu_co[1], alu_out[1]} = alu_f(op[1], r[1], dr[1], alu_c[1]);

  alu_mul_seq #(.SKIP_ZERO(1'b0), .IDLE_OP(9'h000)) dut0 (
    .i_clk(clk), .i_reset(rst_n[0]), .i_start(start[0]), .i_a(a[0]), .i_b(b[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_product(prod[0]), .o_alu_own(own[0]),
    .o_alu_op(op[0]), .o_alu_r(r[0]), .o_alu_dr(dr[0]), .o_alu_c(alu_c[0]),
    .i_alu_out(alu_out[0]), .i_alu_co(alu_co[0])
  );

  alu_mul_seq #(.SKIP_ZERO(1'b1), .IDLE_OP(9'h000)) dut1 (
    .i_clk(clk), .i_reset(rst_n[1]), .i_start(start[1]), .i_a(a[1]), .i_b(b[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_product(prod[1]), .o_alu_own(own[1]),
    .o_alu_op(op[1]), .o_alu_r(r[1]), .o_alu_dr(dr[1]), .o_alu_c(alu_c[1]),
    .i_alu_out(alu_out[1]), .i_alu_co(alu_co[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the view at cycle 1 (first cycle after the accepting edge)
  task automatic start_op(input int sel, input logic [7:0] av, input logic [7:0] bv);
    a[sel] = av;
    b[sel] = bv;
    start[sel] = 1'b1;
    exp_q.push_back(16'(av) * 16'(bv));
    step();
    start[sel] = 1'b0;
    a[sel] = 8'($urandom);
    b[sel] = 8'($urandom);
  endtask

  // Starts at view cycle 1, returns at the done cycle
  task automatic wait_done(input int sel, input int exp_cyc, input logic [7:0] bv,
                           input bit chk_ops, input bit chk_c);
    int cyc = 1;
    bit seen = 0;
    logic [15:0] e;
    logic [8:0] eop;
    while (!seen && cyc <= 40) begin
      if (done[sel] === 1'b1) begin
        seen = 1;
        n_checks++;
        if (cyc != exp_cyc) begin
          n_errors++;
          $display("FAIL done_cycle sel=%0d got=%0d exp=%0d", sel, cyc, exp_cyc);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (prod[sel] !== e) begin
          n_errors++;
          $display("FAIL product sel=%0d got=%h exp=%h", sel, prod[sel], e);
        end
        n_checks++;
        if (busy[sel] !== 1'b0 || own[sel] !== 1'b0) begin
          n_errors++;
          $display("FAIL done_busy sel=%0d busy=%b own=%b exp=0", sel, busy[sel], own[sel]);
        end
      end else begin
        n_checks++;
        if (busy[sel] !== 1'b1 || own[sel] !== 1'b1) begin
          n_errors++;
          $display("FAIL busy sel=%0d cyc=%0d busy=%b own=%b exp=1", sel, cyc, busy[sel], own[sel]);
        end
        if (chk_ops && cyc <= 16) begin
          if (cyc % 2 == 1) eop = bv[(cyc - 1) / 2] ? 9'h004 : 9'h000;
          else              eop = 9'h183;
          n_checks++;
          if (op[sel] !== eop) begin
            n_errors++;
            $display("FAIL alu_op sel=%0d cyc=%0d got=%h exp=%h", sel, cyc, op[sel], eop);
          end
        end
        if (chk_c && (cyc % 2 == 0) && cyc <= 16) begin
          n_checks++;
          if (alu_c[sel] !== (cyc >= 4)) begin
            n_errors++;
            $display("FAIL carry sel=%0d cyc=%0d got=%b exp=%b", sel, cyc, alu_c[sel], cyc >= 4);
          end
        end
        step();
        cyc++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout sel=%0d got=no_done exp=done_at_%0d", sel, exp_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 2'b00;
    start = 2'b00;
    step();
    step();
    rst_n = 2'b11;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (busy[s] !== 1'b0 || done[s] !== 1'b0 || own[s] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_flags sel=%0d busy=%b done=%b own=%b exp=0", s, busy[s], done[s], own[s]);
      end
      n_checks++;
      if (prod[s] !== 16'h0000) begin
        n_errors++;
        $display("FAIL reset_product sel=%0d got=%h exp=0000", s, prod[s]);
      end
      n_checks++;
      if (op[s] !== 9'h000 || r[s] !== 8'h00 || dr[s] !== 8'h00 || alu_c[s] !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_alu sel=%0d op=%h r=%h dr=%h c=%b exp=0", s, op[s], r[s], dr[s], alu_c[s]);
      end
    end
  endtask

  task automatic test_fixed();
    start_op(0, 8'h0D, 8'h0B);
    wait_done(0, 17, 8'h0B, 1, 0);
    step();
    start_op(0, 8'hFF, 8'hFF);
    wait_done(0, 17, 8'hFF, 1, 1);
    step();
  endtask

  task automatic test_skip_zero();
    logic [7:0] bv;
    start_op(1, 8'h55, 8'h00);
    wait_done(1, 9, 8'h00, 0, 0);
    step();
    start_op(1, 8'h55, 8'h01);
    wait_done(1, 10, 8'h01, 0, 0);
    step();
    bv = 8'hB5;
    start_op(1, 8'hC3, bv);
    wait_done(1, 9 + $countones(bv), bv, 0, 0);
    step();
  endtask

  task automatic test_start_held();
    a[0] = 8'd3;
    b[0] = 8'd5;
    start[0] = 1'b1;
    exp_q.push_back(16'h000F);
    step();
    a[0] = 8'd7;
    wait_done(0, 17, 8'd5, 1, 0);
    step();
    n_checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_done busy=%b done=%b exp=0", busy[0], done[0]);
    end
    exp_q.push_back(16'd35);
    step();
    n_checks++;
    if (busy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reaccept busy=%b exp=1", busy[0]);
    end
    start[0] = 1'b0;
    wait_done(0, 17, 8'd5, 0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    logic [15:0] dummy;
    start_op(0, 8'h12, 8'h34);
    repeat (5) step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    dummy = exp_q.pop_front();
    n_checks++;
    if (busy[0] !== 1'b0 || own[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_flags busy=%b own=%b done=%b exp=0", busy[0], own[0], done[0]);
    end
    n_checks++;
    if (prod[0] !== 16'h0000) begin
      n_errors++;
      $display("FAIL midreset_product got=%h exp=0000 (dropped %h)", prod[0], dummy);
    end
    repeat (20) begin
      step();
      if (done[0] !== 1'b0) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin
      n_errors++;
      $display("FAIL midreset_no_done got=done exp=no_done");
    end
    start_op(0, 8'h12, 8'h34);
    wait_done(0, 17, 8'h34, 1, 0);
    step();
  endtask

  task automatic test_back_to_back();
    start_op(0, 8'h10, 8'h10);
    wait_done(0, 17, 8'h10, 1, 0);
    repeat (3) step();
    n_checks++;
    if (prod[0] !== 16'h0100) begin
      n_errors++;
      $display("FAIL product_hold got=%h exp=0100", prod[0]);
    end
    start_op(0, 8'h02, 8'h80);
    wait_done(0, 17, 8'h80, 1, 0);
    step();
    n_checks++;
    if (prod[0] !== 16'h0100) begin
      n_errors++;
      $display("FAIL product_hold2 got=%h exp=0100", prod[0]);
    end
  endtask

  initial begin
    rst_n = 2'b00;
    start = 2'b00;
    a[0] = 8'h00; a[1] = 8'h00;
    b[0] = 8'h00; b[1] = 8'h00;
    test_reset();
    test_fixed();
    test_skip_zero();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
